byte_packet_assembler: RTL and testbench

- Upstream feeder for packet_serializer. Collects a stream of 8-bit bytes, for example from a UART byte receiver or a host interface, into a PACKET_SIZE-bit packet.
- Presents the packet on a parallel bus with a valid/ack handshake. packet_serializer then shifts it into signal_modulator.
- Double-buffered: the next packet can assemble while the previous one waits for ack. A partial packet is discarded after an inter-byte timeout.

---
 rtl/byte_packet_assembler_if.sv | 54 +++++
 rtl/byte_packet_assembler.sv | 148 ++++++++++++++
 tb/tb_byte_packet_assembler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_packet_assembler_if.sv
// ----------------------------------------------------------------------------
// byte_packet_assembler_if
// Purpose : groups the byte-input handshake, the packet-output handshake and
//           the status signals of byte_packet_assembler into one bundle.
// Signals :
//   in_data      [7:0]          byte payload from the upstream source
//   in_valid                    in_data is valid this cycle
//   in_ready                    assembler can accept a byte this cycle
//   packet_out   [PACKET_SIZE]  assembled packet, first byte in the top bits
//   packet_valid                packet_out holds an unacknowledged packet
//   packet_ack                  consumer has taken packet_out
//   drop_pulse                  one-cycle pulse when a partial packet times out
//   byte_count   [CW]           bytes held in the assembly register
// Modports:
//   slave  - the assembler side
//   master - the source/consumer side (testbench or surrounding logic)
// ----------------------------------------------------------------------------
interface byte_packet_assembler_if #(
  parameter int PACKET_SIZE = 184
);
  localparam int N_BYTES = PACKET_SIZE / 8;
  localparam int CW      = $clog2(N_BYTES + 1);

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [PACKET_SIZE-1:0] packet_out;
  logic                   packet_valid;
  logic                   packet_ack;
  logic                   drop_pulse;
  logic [CW-1:0]          byte_count;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output packet_out,
    output packet_valid,
    input  packet_ack,
    output drop_pulse,
    output byte_count
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  packet_out,
    input  packet_valid,
    output packet_ack,
    input  drop_pulse,
    input  byte_count
  );
endinterface

// File: rtl/byte_packet_assembler.sv
// ----------------------------------------------------------------------------
// byte_packet_assembler
// Purpose : collects a stream of bytes (MSB-first) into a PACKET_SIZE-bit
//           packet and presents it on a valid/ack output slot. The next packet
//           assembles while the previous one waits for ack (double buffer).
//           A partial packet is discarded after TIMEOUT_CYCLES idle cycles.
// Ports   :
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - byte_packet_assembler_if.slave (byte input, packet output,
//            drop_pulse and byte_count status)
// ----------------------------------------------------------------------------
module byte_packet_assembler #(
  parameter int PACKET_SIZE    = 184,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  byte_packet_assembler_if.slave  bus
);

  localparam int N_BYTES = PACKET_SIZE / 8;
  localparam int CW      = $clog2(N_BYTES + 1);
  // One extra bit keeps the width non-zero when TIMEOUT_CYCLES is 1.
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N_BYTES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PACKET_SIZE-1:0] shift_q, shift_d;
  logic [PACKET_SIZE-1:0] pout_q, pout_d;
  logic                   pvalid_q, pvalid_d;
  logic                   drop_q, drop_d;
  logic [CW-1:0]          bcount_q, bcount_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;

  logic                   accept_s;
  logic                   slot_free_s;
  logic [PACKET_SIZE-1:0] shifted_s;

  // Byte acceptance and output-slot availability.
  always_comb begin
    accept_s    = bus.in_valid & (state_q == FILL);
    slot_free_s = ~pvalid_q | bus.packet_ack;
    shifted_s   = {shift_q[PACKET_SIZE-9:0], bus.in_data};
  end

  // Next-state logic: assembly, completion hand-off, ack and timeout.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    bcount_d = bcount_q;
    drop_d   = 1'b0;
    tcnt_d   = {TW{1'b0}};

    // A plain ack empties the slot; a same-edge completion below refills it.
    if (pvalid_q && bus.packet_ack) begin
      pvalid_d = 1'b0;
    end else begin
      pvalid_d = pvalid_q;
    end

    case (state_q)
      FILL: begin
        if (accept_s) begin
          shift_d = shifted_s;
          if (bcount_q == LAST_IDX) begin
            if (slot_free_s) begin
              pout_d   = shifted_s;
              pvalid_d = 1'b1;
              bcount_d = {CW{1'b0}};
            end else begin
              // Slot still occupied: hold the complete packet in the shifter.
              bcount_d = FULL_CNT;
              state_d  = FULL;
            end
          end else begin
            bcount_d = bcount_q + CW'(1);
          end
        end else if (bcount_q != {CW{1'b0}}) begin
          if (tcnt_q == TO_LAST) begin
            shift_d  = {PACKET_SIZE{1'b0}};
            bcount_d = {CW{1'b0}};
            drop_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = {TW{1'b0}};
        end
      end
      FULL: begin
        // Held packet moves into the slot as the consumer takes the old one.
        if (pvalid_q && bus.packet_ack) begin
          pout_d   = shift_q;
          pvalid_d = 1'b1;
          bcount_d = {CW{1'b0}};
          state_d  = FILL;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      shift_q  <= {PACKET_SIZE{1'b0}};
      pout_q   <= {PACKET_SIZE{1'b0}};
      pvalid_q <= 1'b0;
      drop_q   <= 1'b0;
      bcount_q <= {CW{1'b0}};
      tcnt_q   <= {TW{1'b0}};
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      drop_q   <= drop_d;
      bcount_q <= bcount_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Output drive; in_ready is combinational from the state so it reads 1 in reset.
  always_comb begin
    bus.in_ready     = (state_q == FILL);
    bus.packet_out   = pout_q;
    bus.packet_valid = pvalid_q;
    bus.drop_pulse   = drop_q;
    bus.byte_count   = bcount_q;
  end

endmodule

// File: tb/tb_byte_packet_assembler.sv
module tb_byte_packet_assembler;

  localparam int PS = 184;
  localparam int TO = 10;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ack;
    logic       exp_ready;
    logic       exp_pv;
    logic [4:0] exp_bc;
    logic       exp_drop;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t tbl[$];

  byte_packet_assembler_if #(.PACKET_SIZE(PS)) bus();

  byte_packet_assembler #(
    .PACKET_SIZE   (PS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic ack, input logic rdy,
                     input logic pv, input logic [4:0] bc, input logic drop);
    vec_t e;
    e.v = v; e.d = d; e.ack = ack; e.exp_ready = rdy;
    e.exp_pv = pv; e.exp_bc = bc; e.exp_drop = drop;
    tbl.push_back(e);
  endtask

  task automatic status(input string tag, input logic rdy, input logic pv, input logic [4:0] bc);
    chk({tag, " in_ready"}, PS'(bus.in_ready), PS'(rdy));
    chk({tag, " packet_valid"}, PS'(bus.packet_valid), PS'(pv));
    chk({tag, " byte_count"}, PS'(bus.byte_count), PS'(bc));
  endtask

  initial begin
    string msg;
    checks = 0;
    errors = 0;
    msg = "This is a test message!";

    // Timeout table: 5 bytes then idle until drop.
    for (int i = 1; i <= 5; i++) add(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 5'(i), 1'b0);
    for (int i = 1; i <= 9; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    // Byte arriving on the last idle cycle wins over the timeout.
    for (int i = 1; i <= 5; i++) add(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 5'(i), 1'b0);
    for (int i = 1; i <= 9; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);
    add(1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0);
    for (int i = 1; i <= 9; i++) add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    // Fresh packet 0x01..0x17 after the drops.
    for (int i = 1; i <= 22; i++) add(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 5'(i), 1'b0);
    add(1'b1, 8'd23, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.packet_ack = 1'b0;
    tick();
    chk("reset packet_out", bus.packet_out, {PS{1'b0}});
    chk("reset drop_pulse", PS'(bus.drop_pulse), PS'(1'b0));
    status("reset", 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Message packet, ack tied high.
    bus.packet_ack = 1'b1;
    for (int i = 0; i < 23; i++) begin
      send(msg[i]);
      if (i == 11) status("msg mid", 1'b1, 1'b0, 5'd12);
    end
    status("msg done", 1'b1, 1'b1, 5'd0);
    chk("msg packet_out", bus.packet_out, 184'h5468697320697320612074657374206d65737361676521);
    tick();
    chk("msg acked valid", PS'(bus.packet_valid), PS'(1'b0));
    bus.packet_ack = 1'b0;

    // Double buffering: A waits, B fills the shifter.
    for (int i = 0; i < 23; i++) send(8'h11);
    status("A done", 1'b1, 1'b1, 5'd0);
    for (int i = 0; i < 23; i++) send(8'h22);
    status("B held", 1'b0, 1'b1, 5'd23);
    chk("B held packet_out", bus.packet_out, {23{8'h11}});
    bus.in_valid = 1'b1;
    bus.in_data = 8'h33;
    tick();
    tick();
    bus.in_valid = 1'b0;
    status("stall", 1'b0, 1'b1, 5'd23);
    chk("stall packet_out", bus.packet_out, {23{8'h11}});
    bus.packet_ack = 1'b1;
    tick();
    bus.packet_ack = 1'b0;
    status("B moved", 1'b1, 1'b1, 5'd0);
    chk("B packet_out", bus.packet_out, {23{8'h22}});
    bus.packet_ack = 1'b1;
    tick();
    bus.packet_ack = 1'b0;
    chk("B acked valid", PS'(bus.packet_valid), PS'(1'b0));

    // Table-driven timeout vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_data = tbl[i].d;
      bus.packet_ack = tbl[i].ack;
      tick();
      chk($sformatf("vec%0d in_ready", i), PS'(bus.in_ready), PS'(tbl[i].exp_ready));
      chk($sformatf("vec%0d packet_valid", i), PS'(bus.packet_valid), PS'(tbl[i].exp_pv));
      chk($sformatf("vec%0d byte_count", i), PS'(bus.byte_count), PS'(tbl[i].exp_bc));
      chk($sformatf("vec%0d drop_pulse", i), PS'(bus.drop_pulse), PS'(tbl[i].exp_drop));
    end
    bus.in_valid = 1'b0;
    bus.packet_ack = 1'b0;
    chk("post-drop packet_out", bus.packet_out, 184'h0102030405060708090a0b0c0d0e0f1011121314151617);

    // Clear slot, then an ack with nothing valid must be ignored.
    bus.packet_ack = 1'b1;
    tick();
    status("clear", 1'b1, 1'b0, 5'd0);
    tick();
    bus.packet_ack = 1'b0;
    status("idle ack", 1'b1, 1'b0, 5'd0);
    chk("idle ack drop", PS'(bus.drop_pulse), PS'(1'b0));

    // Completion on the same edge as the ack of the previous packet.
    for (int i = 0; i < 23; i++) send(8'h5A);
    chk("P5A packet_out", bus.packet_out, {23{8'h5A}});
    for (int i = 0; i < 22; i++) begin
      send(8'hC3);
      chk("pre-swap valid", PS'(bus.packet_valid), PS'(1'b1));
    end
    bus.packet_ack = 1'b1;
    send(8'hC3);
    bus.packet_ack = 1'b0;
    status("swap", 1'b1, 1'b1, 5'd0);
    chk("swap packet_out", bus.packet_out, {23{8'hC3}});
    tick();
    chk("swap stable", bus.packet_out, {23{8'hC3}});
    chk("swap valid", PS'(bus.packet_valid), PS'(1'b1));

    // Asynchronous reset with a valid packet and a 12-byte partial.
    for (int i = 0; i < 12; i++) send(8'h44);
    status("pre-reset", 1'b1, 1'b1, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    status("async reset", 1'b1, 1'b0, 5'd0);
    chk("async reset packet_out", bus.packet_out, {PS{1'b0}});
    chk("async reset drop", PS'(bus.drop_pulse), PS'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) send(8'h99);
    status("post-reset 22", 1'b1, 1'b0, 5'd22);
    send(8'h99);
    status("post-reset 23", 1'b1, 1'b1, 5'd0);
    chk("post-reset packet_out", bus.packet_out, {23{8'h99}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
